// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart mtimecmp/MSIP.
// Optional CLINT_MTIME_LATCH_EN: MTIME-low read snapshots mtime[63:32] for a tear-free MTIME-high read.
module clint_mh #(
   parameter int unsigned NHART   = 2,
   parameter logic [31:0] BASE    = 32'h0200_0000,
   parameter int unsigned PRESC_W = 8
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             timer_en,
   input  logic             wready,
   output logic             wvalid,
   input  logic [31:0]      waddr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb,
   input  logic             rready,
   output logic             rvalid,
   input  logic [31:0]      raddr,
   output logic             rresp,
   output logic             rerr,
   output logic [31:0]      rdata,
   output logic [NHART-1:0] timer_irq,
   output logic [NHART-1:0] sw_irq,
   output logic [NHART-1:0] ex_irq
);

   localparam logic [31:0] OFF_MTIMECMP = 32'h0000_4000;
   localparam logic [31:0] OFF_PRESC    = 32'h0000_BFF0;
   localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
   localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;

   logic [63:0]        mtime, mtime_nxt;
   logic [PRESC_W-1:0] presc, presc_nxt;
   logic [PRESC_W-1:0] cnt, cnt_nxt;
   logic [63:0]        cmp     [NHART];
   logic [63:0]        cmp_nxt [NHART];
   logic [NHART-1:0]   sw_nxt, ex_nxt, tirq_nxt;
   logic [31:0]        woff, roff, rval;
   logic               rmap;

`ifdef CLINT_MTIME_LATCH_EN
   logic [31:0]        mtime_hi_shadow;
`endif

   assign wvalid = 1'b1;
   assign rvalid = 1'b1;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      merge = old;
      for (int unsigned b = 0; b < 4; b++)
         if (strb[b]) merge[8*b +: 8] = nw[8*b +: 8];
   endfunction

   // Next-state for all writable state; an MTIME write overrides the tick
   always_comb begin
      woff      = waddr - BASE;
      mtime_nxt = mtime;
      presc_nxt = presc;
      cnt_nxt   = cnt;
      sw_nxt    = sw_irq;
      ex_nxt    = ex_irq;
      for (int unsigned h = 0; h < NHART; h++) cmp_nxt[h] = cmp[h];

      if (timer_en) begin
         if (cnt == presc) begin
            cnt_nxt   = '0;
            mtime_nxt = mtime + 64'd1;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end

      if (wready) begin
         for (int unsigned h = 0; h < NHART; h++) begin
            if (woff == 32'(4*h)) begin
               if (wstrb[0]) sw_nxt[h] = wdata[0];
               if (wstrb[2]) ex_nxt[h] = wdata[16];
            end
            if (woff == OFF_MTIMECMP + 32'(8*h))
               cmp_nxt[h][31:0] = merge(cmp[h][31:0], wdata, wstrb);
            if (woff == OFF_MTIMECMP + 32'(8*h) + 32'd4)
               cmp_nxt[h][63:32] = merge(cmp[h][63:32], wdata, wstrb);
         end
         if (woff == OFF_PRESC) begin
            for (int unsigned i = 0; i < PRESC_W; i++)
               if (wstrb[i/8]) presc_nxt[i] = wdata[i];
            cnt_nxt = '0;
         end
         if (woff == OFF_MTIME_LO) begin
            mtime_nxt = {mtime[63:32], merge(mtime[31:0], wdata, wstrb)};
            cnt_nxt   = '0;
         end
         if (woff == OFF_MTIME_HI) begin
            mtime_nxt = {merge(mtime[63:32], wdata, wstrb), mtime[31:0]};
            cnt_nxt   = '0;
         end
      end

      for (int unsigned h = 0; h < NHART; h++) tirq_nxt[h] = (mtime_nxt >= cmp_nxt[h]);
   end

   // Read mux works on pre-edge register contents (read-before-write)
   always_comb begin
      roff = raddr - BASE;
      rval = '0;
      rmap = 1'b0;
      for (int unsigned h = 0; h < NHART; h++) begin
         if (roff == 32'(4*h)) begin
            rmap = 1'b1;
            rval = {15'd0, ex_irq[h], 15'd0, sw_irq[h]};
         end
         if (roff == OFF_MTIMECMP + 32'(8*h)) begin
            rmap = 1'b1;
            rval = cmp[h][31:0];
         end
         if (roff == OFF_MTIMECMP + 32'(8*h) + 32'd4) begin
            rmap = 1'b1;
            rval = cmp[h][63:32];
         end
      end
      if (roff == OFF_PRESC) begin
         rmap = 1'b1;
         rval = 32'(presc);
      end
      if (roff == OFF_MTIME_LO) begin
         rmap = 1'b1;
         rval = mtime[31:0];
      end
      if (roff == OFF_MTIME_HI) begin
         rmap = 1'b1;
`ifdef CLINT_MTIME_LATCH_EN
         rval = mtime_hi_shadow;
`else
         rval = mtime[63:32];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         mtime     <= '0;
         presc     <= '0;
         cnt       <= '0;
         sw_irq    <= '0;
         ex_irq    <= '0;
         timer_irq <= '0;
         rresp     <= 1'b0;
         rerr      <= 1'b0;
         rdata     <= '0;
         for (int unsigned h = 0; h < NHART; h++) cmp[h] <= '1;
      end else begin
         mtime     <= mtime_nxt;
         presc     <= presc_nxt;
         cnt       <= cnt_nxt;
         sw_irq    <= sw_nxt;
         ex_irq    <= ex_nxt;
         timer_irq <= tirq_nxt;
         rresp     <= rready;
         rerr      <= rready && !rmap;
         if (rready) rdata <= rval;
         for (int unsigned h = 0; h < NHART; h++) cmp[h] <= cmp_nxt[h];
      end
   end

`ifdef CLINT_MTIME_LATCH_EN
   always_ff @(posedge clk) begin
      if (!resetb)
         mtime_hi_shadow <= '0;
      else if (rready && roff == OFF_MTIME_LO)
         mtime_hi_shadow <= mtime[63:32];
   end
`endif

endmodule

// File: tb/tb_clint_mh.sv
// Directed self-checking bench for clint_mh (NHART=2); honours CLINT_MTIME_LATCH_EN when defined.
module tb_clint_mh;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        resetb, timer_en, wready, rready;
   logic        wvalid, rvalid, rresp, rerr;
   logic [31:0] waddr, wdata, raddr, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  timer_irq, sw_irq, ex_irq;

   int checks = 0;
   int errors = 0;

   clint_mh #(.NHART(2), .BASE(BASE), .PRESC_W(8)) dut (
      .clk(clk), .resetb(resetb), .timer_en(timer_en),
      .wready(wready), .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
      .rready(rready), .rvalid(rvalid), .raddr(raddr),
      .rresp(rresp), .rerr(rerr), .rdata(rdata),
      .timer_irq(timer_irq), .sw_irq(sw_irq), .ex_irq(ex_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
      waddr  = BASE + off;
      wdata  = d;
      wstrb  = s;
      wready = 1'b1;
      step();
      wready = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
      raddr  = BASE + off;
      rready = 1'b1;
      step();
      rready = 1'b0;
      check({tag, ".rresp"}, 64'(rresp), 64'd1);
      check({tag, ".rerr"},  64'(rerr),  64'd0);
      check({tag, ".rdata"}, 64'(rdata), 64'(exp));
   endtask

   initial begin
      resetb = 1'b0; timer_en = 1'b0; wready = 1'b0; rready = 1'b0;
      waddr = '0; wdata = '0; wstrb = '0; raddr = '0;
      step(); step();
      resetb = 1'b1;

      // reset state
      check("rst.timer_irq", 64'(timer_irq), 64'd0);
      check("rst.sw_irq",    64'(sw_irq),    64'd0);
      check("rst.ex_irq",    64'(ex_irq),    64'd0);
      check("rst.rresp",     64'(rresp),     64'd0);
      check("rst.rerr",      64'(rerr),      64'd0);
      check("rst.rdata",     64'(rdata),     64'd0);
      check("tie.wvalid",    64'(wvalid),    64'd1);
      check("tie.rvalid",    64'(rvalid),    64'd1);
      rd_chk("rst.cmp1_hi", 32'h400C, 32'hFFFF_FFFF);
      step();
      check("idle.rresp", 64'(rresp), 64'd0);
      check("idle.rdata_hold", 64'(rdata), 64'h0000_0000_FFFF_FFFF);

      // prescaler 3: 12 ticks -> 3 increments
      wr(32'hBFF0, 32'd3, 4'hF);
      rd_chk("presc", 32'hBFF0, 32'd3);
      timer_en = 1'b1;
      repeat (12) step();
      timer_en = 1'b0;
      rd_chk("presc3.lo", 32'hBFF8, 32'd3);
      rd_chk("presc3.hi", 32'hBFFC, 32'd0);

      // mtimecmp[0] = 10 with PRESC=0, mtime starts at 3
      wr(32'hBFF0, 32'd0, 4'hF);
      wr(32'h4004, 32'd0, 4'hF);
      check("cmp_hi_only.irq", 64'(timer_irq), 64'd0);
      wr(32'h4000, 32'd10, 4'hF);
      timer_en = 1'b1;
      repeat (6) step();
      check("mtime9.irq", 64'(timer_irq), 64'd0);
      step();
      timer_en = 1'b0;
      check("mtime10.irq", 64'(timer_irq), 64'b01);
      rd_chk("mtime10.lo", 32'hBFF8, 32'd10);
      wr(32'h4000, 32'd100, 4'hF);
      check("cmp_raise.irq", 64'(timer_irq), 64'd0);

      // MSIP byte strobes
      wr(32'h0004, 32'h0001_0001, 4'b0001);
      check("msip_b0.sw", 64'(sw_irq), 64'b10);
      check("msip_b0.ex", 64'(ex_irq), 64'b00);
      wr(32'h0004, 32'h0001_0001, 4'b0100);
      check("msip_b2.ex", 64'(ex_irq), 64'b10);
      rd_chk("msip1", 32'h0004, 32'h0001_0001);
      wr(32'h0004, 32'h0000_0000, 4'hF);
      check("msip_clr.sw", 64'(sw_irq), 64'b00);
      check("msip_clr.ex", 64'(ex_irq), 64'b00);

      // partial strobe on mtimecmp[1] low
      wr(32'h4008, 32'h0000_AB00, 4'b0010);
      rd_chk("cmp1_lo_strb", 32'h4008, 32'hFFFF_ABFF);

      // low-word carry into high word
      wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      wr(32'hBFFC, 32'h0000_0000, 4'hF);
      timer_en = 1'b1;
      step();
      timer_en = 1'b0;
      check("carry.irq", 64'(timer_irq), 64'b01);
      rd_chk("carry.lo", 32'hBFF8, 32'd0);
      rd_chk("carry.hi", 32'hBFFC, 32'd1);

      // snapshot: read low, tick, read high
      wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      wr(32'hBFFC, 32'h0000_0000, 4'hF);
      rd_chk("snap.lo", 32'hBFF8, 32'hFFFF_FFFF);
      timer_en = 1'b1;
      step();
      timer_en = 1'b0;
`ifdef CLINT_MTIME_LATCH_EN
      rd_chk("snap.hi", 32'hBFFC, 32'd0);
`else
      rd_chk("snap.hi", 32'hBFFC, 32'd1);
`endif

      // unmapped read
      raddr  = BASE + 32'h8000;
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("unmap.rresp", 64'(rresp), 64'd1);
      check("unmap.rerr",  64'(rerr),  64'd1);
      check("unmap.rdata", 64'(rdata), 64'd0);

      // MTIME write coincident with prescaler rollover
      wr(32'hBFF0, 32'd1, 4'hF);
      wr(32'hBFF8, 32'h20, 4'hF);
      timer_en = 1'b1;
      step();
      waddr = BASE + 32'hBFF8; wdata = 32'h55; wstrb = 4'hF; wready = 1'b1;
      step();
      wready = 1'b0;
      timer_en = 1'b0;
      rd_chk("wr_roll.lo", 32'hBFF8, 32'h55);
      timer_en = 1'b1;
      step();
      timer_en = 1'b0;
      rd_chk("cnt_clr.lo", 32'hBFF8, 32'h55);
      timer_en = 1'b1;
      step();
      timer_en = 1'b0;
      rd_chk("roll_after.lo", 32'hBFF8, 32'h56);

      // simultaneous read/write, then read-before-write on same address
      raddr = BASE + 32'h4000; rready = 1'b1;
      waddr = BASE + 32'h0000; wdata = 32'h1; wstrb = 4'hF; wready = 1'b1;
      step();
      rready = 1'b0; wready = 1'b0;
      check("rw.rdata", 64'(rdata), 64'd100);
      check("rw.sw",    64'(sw_irq), 64'b01);
      raddr = BASE + 32'h0000; rready = 1'b1;
      waddr = BASE + 32'h0000; wdata = 32'h0; wstrb = 4'hF; wready = 1'b1;
      step();
      rready = 1'b0; wready = 1'b0;
      check("rbw.rdata", 64'(rdata), 64'd1);
      check("rbw.sw",    64'(sw_irq), 64'b00);

      // reset during a pending read
      wr(32'h0000, 32'h0001_0001, 4'hF);
      raddr = BASE + 32'hBFF8; rready = 1'b1; resetb = 1'b0;
      step();
      rready = 1'b0; resetb = 1'b1;
      check("midrst.rresp", 64'(rresp), 64'd0);
      check("midrst.rdata", 64'(rdata), 64'd0);
      check("midrst.sw",    64'(sw_irq), 64'd0);
      check("midrst.ex",    64'(ex_irq), 64'd0);
      check("midrst.irq",   64'(timer_irq), 64'd0);
      rd_chk("midrst.mtime", 32'hBFF8, 32'd0);
      rd_chk("midrst.cmp0",  32'h4000, 32'hFFFF_FFFF);
      rd_chk("midrst.presc", 32'hBFF0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
